load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mips_pkg.sv | 67 ++++++
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_align.sv | 36 +++
 rtl/load_store_unit.sv | 101 ++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: load/store opcodes, LSU state encoding and
// small decode/merge helpers used by the load/store unit.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_known(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Halfword accesses need an even address, word accesses a multiple of 4.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = off[0];
            OP_LW, OP_SW:         mis = (off != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Replace one big-endian lane of a memory word with store data (SB/SH).
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  off,
                                                input logic [5:0]  op);
        logic [31:0] merged;
        merged = word;
        if (op == OP_SB) begin
            case (off)
                2'd0:    merged[31:24] = wdata[7:0];
                2'd1:    merged[23:16] = wdata[7:0];
                2'd2:    merged[15:8]  = wdata[7:0];
                default: merged[7:0]   = wdata[7:0];
            endcase
        end else if (op == OP_SH) begin
            if (off[1]) merged[15:0]  = wdata[15:0];
            else        merged[31:16] = wdata[15:0];
        end
        return merged;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
interface load_store_unit_if;
    logic        req;
    logic        ready;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        memWrite;
    logic        memRead;
    logic [31:0] Address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    // Pipeline plus data memory: issues requests and returns memory words.
    modport master (
        output req, opcode, addr, wdata, read_data,
        input  ready, done, rdata, misaligned, memWrite, memRead, Address, write_data
    );

    // The load/store unit itself.
    modport slave (
        input  req, opcode, addr, wdata, read_data,
        output ready, done, rdata, misaligned, memWrite, memRead, Address, write_data
    );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a big-endian memory word and
// sign- or zero-extends it according to the load opcode.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [5:0]  opcode,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        byte_sel = word[31:24];
        half_sel = offset[1] ? word[15:0] : word[31:16];
        result   = word;
        case (offset)
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            2'd3:    byte_sel = word[7:0];
            default: byte_sel = word[31:24];
        endcase
        case (opcode)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'h0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle MIPS load/store unit. Loads read one word, SW writes one word,
// SB/SH read-modify-write one word; misaligned or unknown requests abort.
module load_store_unit
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus
);

    lsu_state_t  state_q, state_d;
    logic [5:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;       // store data, replaced by the merged word for SB/SH
    logic        mis_q;
    logic [31:0] rdata_q;
    logic [31:0] load_result;
    logic        accept;

    assign accept = bus.req && (state_q == IDLE);

    load_align u_load_align (
        .word   (bus.read_data),
        .offset (addr_q[1:0]),
        .opcode (op_q),
        .result (load_result)
    );

    // Next-state selection and state-decoded outputs.
    always_comb begin
        state_d        = state_q;
        bus.ready      = 1'b0;
        bus.done       = 1'b0;
        bus.misaligned = 1'b0;
        bus.memRead    = 1'b0;
        bus.memWrite   = 1'b0;
        bus.Address    = 32'h0;
        bus.write_data = 32'h0;
        case (state_q)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.req) begin
                    if (!is_known(bus.opcode) || is_misaligned(bus.opcode, bus.addr[1:0]))
                        state_d = DONE;
                    else if (bus.opcode == OP_SW)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                bus.memRead = 1'b1;
                bus.Address = {addr_q[31:2], 2'b00};
                state_d     = is_load(op_q) ? DONE : WRITE;
            end
            WRITE: begin
                bus.memWrite   = 1'b1;
                bus.Address    = {addr_q[31:2], 2'b00};
                bus.write_data = data_q;
                state_d        = DONE;
            end
            DONE: begin
                bus.done       = 1'b1;
                bus.misaligned = mis_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, request capture, load result and store merge.
    always_ff @(posedge clk) begin
        // NOTE: the request registers and rdata are ordinary flops (no memory array), so all are cleared by reset; rdata must read 0 afterwards.
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 6'h0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            mis_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            if (accept) begin
                op_q   <= bus.opcode;
                addr_q <= bus.addr;
                data_q <= bus.wdata;
                mis_q  <= is_misaligned(bus.opcode, bus.addr[1:0]);
            end
            if (state_q == READ) begin
                if (is_load(op_q))
                    rdata_q <= load_result;
                else
                    data_q  <= merge_store(bus.read_data, data_q, addr_q[1:0], op_q);
            end
        end
    end

    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// random accesses, all checked against a byte-level reference memory model.
module tb_load_store_unit;

    localparam logic [5:0] T_LB  = 6'h20;
    localparam logic [5:0] T_LH  = 6'h21;
    localparam logic [5:0] T_LW  = 6'h23;
    localparam logic [5:0] T_LBU = 6'h24;
    localparam logic [5:0] T_LHU = 6'h25;
    localparam logic [5:0] T_SB  = 6'h28;
    localparam logic [5:0] T_SH  = 6'h29;
    localparam logic [5:0] T_SW  = 6'h2B;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [31:0] exp_rdata = 32'h0;

    logic [31:0] mem     [0:63];   // memory seen by the DUT
    logic [31:0] ref_mem [0:63];   // reference model contents

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.read_data = mem[bus.Address[7:2]];

    always @(posedge clk) begin
        if (bus.memWrite) mem[bus.Address[7:2]] <= bus.write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        mem[idx]     <= val;
        ref_mem[idx]  = val;
    endtask

    function automatic int op_size(input logic [5:0] op);
        case (op)
            T_LB, T_LBU, T_SB: return 1;
            T_LH, T_LHU, T_SH: return 2;
            T_LW, T_SW:        return 4;
            default:           return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [5:0] op);
        return op == T_LB || op == T_LH || op == T_LW || op == T_LBU || op == T_LHU;
    endfunction

    function automatic logic [31:0] size_mask(input int size);
        return (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (size * 8)) - 32'd1);
    endfunction

    // Big-endian: the addressed field ends (4 - size - offset) bytes above bit 0.
    function automatic logic [31:0] model_load(input logic [31:0] word, input int off,
                                               input int size, input bit sgn);
        logic [31:0] mask, v;
        int sh;
        sh   = (4 - size - off) * 8;
        mask = size_mask(size);
        v    = (word >> sh) & mask;
        if (sgn && v[size * 8 - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] wd,
                                                input int off, input int size);
        logic [31:0] mask;
        int sh;
        sh   = (4 - size - off) * 8;
        mask = size_mask(size);
        return (word & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    // One complete access from the cycle after the previous done (or reset) to its done.
    task automatic access(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] wd);
        int size, off, cyc, rd_n, wr_n, bus_err, exp_cyc;
        bit ld, st, mis, ok, seen_done;
        logic seen_mis;
        logic [31:0] seen_wd, seen_rdata, new_word;
        size = op_size(op);
        off  = int'(a[1:0]);
        ld   = op_is_load(op);
        st   = (size != 0) && !ld;
        mis  = (size != 0) && (off % size != 0);
        ok   = (size != 0) && !mis;
        if (!ok)                 exp_cyc = 2;
        else if (ld || size == 4) exp_cyc = 3;
        else                     exp_cyc = 4;

        @(negedge clk);
        check({tag, ":ready"}, bus.ready, 1'b1);
        bus.req = 1'b1; bus.opcode = op; bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        // Garbage on the request lines while busy must be ignored.
        bus.req = 1'($urandom); bus.opcode = 6'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
        cyc = 1; rd_n = 0; wr_n = 0; bus_err = 0; seen_done = 0;
        seen_mis = 1'b0; seen_wd = 32'h0; seen_rdata = 32'h0;
        while (!seen_done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.ready !== 1'b0) bus_err++;
            if (bus.memRead === 1'b1 && bus.memWrite === 1'b1) bus_err++;
            if (bus.memRead === 1'b1 || bus.memWrite === 1'b1) begin
                if (bus.Address !== {a[31:2], 2'b00}) bus_err++;
            end else if (bus.Address !== 32'h0) bus_err++;
            if (bus.memWrite === 1'b1) begin
                wr_n++;
                seen_wd = bus.write_data;
            end else if (bus.write_data !== 32'h0) bus_err++;
            if (bus.memRead === 1'b1) rd_n++;
            if (bus.done === 1'b1) begin
                seen_done  = 1;
                seen_mis   = bus.misaligned;
                seen_rdata = bus.rdata;
            end else if (bus.misaligned !== 1'b0) bus_err++;
        end
        bus.req = 1'b0;

        if (ld && ok) exp_rdata = model_load(ref_mem[a[7:2]], off, size, op == T_LB || op == T_LH);
        new_word = 32'h0;
        if (st && ok) begin
            new_word = (size == 4) ? wd : model_store(ref_mem[a[7:2]], wd, off, size);
            ref_mem[a[7:2]] = new_word;
        end

        check({tag, ":done_seen"}, 32'(seen_done), 32'd1);
        check({tag, ":cycles"}, cyc, exp_cyc);
        check({tag, ":memRead_cycles"}, rd_n, (ok && (ld || size < 4)) ? 1 : 0);
        check({tag, ":memWrite_cycles"}, wr_n, (st && ok) ? 1 : 0);
        check({tag, ":bus_rules"}, bus_err, 0);
        check({tag, ":misaligned"}, seen_mis, mis);
        check({tag, ":rdata"}, seen_rdata, exp_rdata);
        if (st && ok) check({tag, ":write_data"}, seen_wd, new_word);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ":ready"}, bus.ready, 1'b1);
        check({tag, ":done"}, bus.done, 1'b0);
        check({tag, ":misaligned"}, bus.misaligned, 1'b0);
        check({tag, ":memRead"}, bus.memRead, 1'b0);
        check({tag, ":memWrite"}, bus.memWrite, 1'b0);
        check({tag, ":Address"}, bus.Address, 32'h0);
        check({tag, ":write_data"}, bus.write_data, 32'h0);
        check({tag, ":rdata"}, bus.rdata, exp_rdata);
    endtask

    initial begin : stimulus
        logic [5:0] ops [0:8];
        int wr_seen;
        ops = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW, 6'h3F};
        bus.req = 1'b0; bus.opcode = 6'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
        for (int i = 0; i < 64; i++) poke(i, $urandom);

        // Reset state.
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_rdata = 32'h0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Word load.
        poke(32'h10 >> 2, 32'h1122_3344);
        access("lw_10", T_LW, 32'h10, 32'h0);

        // Byte loads, signed and unsigned, lowest lane.
        poke(32'h10 >> 2, 32'h1122_33F4);
        access("lb_13", T_LB, 32'h13, 32'h0);
        access("lbu_13", T_LBU, 32'h13, 32'h0);
        access("lb_10", T_LB, 32'h10, 32'h0);

        // Halfword loads and a misaligned halfword.
        poke(32'h10 >> 2, 32'h8001_ABCD);
        access("lh_12", T_LH, 32'h12, 32'h0);
        access("lhu_12", T_LHU, 32'h12, 32'h0);
        access("lh_10", T_LH, 32'h10, 32'h0);
        access("lh_11", T_LH, 32'h11, 32'h0);

        // Byte store read-modify-write, then read back.
        poke(32'h20 >> 2, 32'h1122_3344);
        access("sb_21", T_SB, 32'h21, 32'h0000_00AA);
        access("lw_20", T_LW, 32'h20, 32'h0);
        access("sh_22", T_SH, 32'h22, 32'h1234_BEEF);
        access("lw_20b", T_LW, 32'h20, 32'h0);

        // Misaligned word store, back-to-back load, unknown opcode.
        access("sw_06", T_SW, 32'h06, 32'hDEAD_BEEF);
        access("lw_b2b", T_LW, 32'h20, 32'h0);
        access("unknown", 6'h3F, 32'h24, 32'h0);

        // Reset while an SH is in READ: no write, all outputs cleared.
        @(negedge clk);
        bus.req = 1'b1; bus.opcode = T_SH; bus.addr = 32'h20; bus.wdata = 32'h0000_5555;
        @(posedge clk); #1 bus.req = 1'b0;
        @(negedge clk);
        check("rst_read:in_read", bus.memRead, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_rdata = 32'h0;
        wr_seen = 0;
        @(negedge clk);
        check_idle_outputs("rst_read");
        for (int i = 0; i < 3; i++) begin
            if (bus.memWrite === 1'b1) wr_seen++;
            @(negedge clk);
        end
        check("rst_read:no_write", wr_seen, 0);
        access("lw_after_rst", T_LW, 32'h20, 32'h0);

        // Reset while SW is in WRITE: the write still lands at that edge.
        @(negedge clk);
        bus.req = 1'b1; bus.opcode = T_SW; bus.addr = 32'h30; bus.wdata = 32'hCAFE_F00D;
        @(posedge clk); #1 bus.req = 1'b0;
        @(negedge clk);
        check("rst_write:in_write", bus.memWrite, 1'b1);
        reset = 1'b1;
        ref_mem[32'h30 >> 2] = 32'hCAFE_F00D;
        @(posedge clk); #1 reset = 1'b0;
        exp_rdata = 32'h0;
        @(negedge clk);
        check_idle_outputs("rst_write");
        access("lw_30", T_LW, 32'h30, 32'h0);

        // Random accesses against the reference model.
        for (int n = 0; n < 80; n++) begin
            access($sformatf("rnd%0d", n), ops[$urandom_range(0, 8)],
                   32'($urandom_range(0, 255)), $urandom);
        end

        // Memory contents must match the model everywhere (no stray writes).
        @(negedge clk);
        for (int i = 0; i < 64; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
